fetch_unit: RTL and testbench

//  Instruction-fetch front end of the darkriscv core: owns the PC, drives a

---
 rtl/darkriscv_pkg.sv | 13 +
 rtl/fetch_unit_reset_pipe.sv | 22 ++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/darkriscv_pkg.sv
// Shared types and constants for the darkriscv fetch front end.
package darkriscv_pkg;

  localparam logic [31:0] NOP_INSN     = 32'h00000013;
  localparam logic [31:0] DEF_RESET_PC = 32'h00000000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_reset_pipe.sv
// Two-flop shifter that stretches rst into xreset for the downstream stages.
module reset_pipe (
  input  logic clk,
  input  logic rst,
  output logic xreset
);

  logic [1:0] pipe_q;
  logic [1:0] pipe_d;

  always_comb begin
    pipe_d = {pipe_q[0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= 2'b11;
    else     pipe_q <= pipe_d;
  end

  assign xreset = pipe_q[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, imem request, insn/flush/xreset to the decoder,
// with stall handling, jump/branch redirects and post-redirect flushing.
module fetch_unit
  import darkriscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        flush,
  output logic        xreset,
  output logic        misalign
);

  localparam logic [1:0] FLUSH_LD = 2'(FLUSH_CYCLES);

  logic         xreset_q;
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  insn_q, insn_d;
  logic [31:0]  insn_pc_q, insn_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [1:0]   flush_cnt_q, flush_cnt_d;
  logic         misalign_q, misalign_d;
  logic         data_valid_q, data_valid_d;
  logic         hlt_q, hlt_d;
  logic [31:0]  hold_data_q, hold_data_d;

  logic         advance;
  logic         apply;
  logic [31:0]  target;

  reset_pipe u_reset_pipe (
    .clk    (clk),
    .rst    (rst),
    .xreset (xreset_q)
  );

  // fetch_pc_q is the address whose word is on imem_data this cycle; hold_data_q
  // keeps that word across a stall, since the memory re-reads pc_q while halted.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    insn_d       = insn_q;
    insn_pc_d    = insn_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    flush_cnt_d  = flush_cnt_q;
    misalign_d   = 1'b0;
    data_valid_d = !xreset_q;
    hlt_d        = hlt;
    hold_data_d  = hold_data_q;

    advance = !xreset_q && !hlt;
    apply   = advance && (redirect || pend_valid_q);
    target  = redirect ? redirect_pc : pend_pc_q;

    if (!xreset_q && hlt && redirect) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_pc;
    end

    if (hlt && !hlt_q) hold_data_d = imem_data;

    if (advance) begin
      pend_valid_d = 1'b0;
      fetch_pc_d   = pc_q;
      if (apply) begin
        pc_d        = {target[31:2], 2'b00};
        flush_cnt_d = FLUSH_LD;
        misalign_d  = (target[1:0] != 2'b00);
      end else begin
        pc_d = pc_q + 32'd4;
        if (flush_cnt_q != 2'd0) flush_cnt_d = flush_cnt_q - 2'd1;
      end
      if (data_valid_q) begin
        insn_d    = hlt_q ? hold_data_q : imem_data;
        insn_pc_d = fetch_pc_q;
      end
    end

    if (xreset_q) begin
      state_d = S_RESET;
    end else if (advance) begin
      if (apply)                     state_d = S_FLUSH;
      else if (flush_cnt_d == 2'd0)  state_d = S_RUN;
      else                           state_d = S_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RESET;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      insn_q       <= NOP_INSN;
      insn_pc_q    <= RESET_PC;
      pend_pc_q    <= 32'h0;
      pend_valid_q <= 1'b0;
      flush_cnt_q  <= 2'd0;
      misalign_q   <= 1'b0;
      data_valid_q <= 1'b0;
      hlt_q        <= 1'b0;
      hold_data_q  <= NOP_INSN;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      insn_q       <= insn_d;
      insn_pc_q    <= insn_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      flush_cnt_q  <= flush_cnt_d;
      misalign_q   <= misalign_d;
      data_valid_q <= data_valid_d;
      hlt_q        <= hlt_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = !xreset_q;
  assign insn      = insn_q;
  assign insn_pc   = insn_pc_q;
  assign flush     = (flush_cnt_q != 2'd0);
  assign xreset    = xreset_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a one-cycle registered instruction memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, hlt, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, insn, insn_pc;
  logic        imem_req, flush, xreset, misalign;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  fetch_unit dut (
    .clk(clk), .rst(rst), .hlt(hlt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data),
    .insn(insn), .insn_pc(insn_pc), .flush(flush), .xreset(xreset), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in cycle C after reset release: xreset=0, imem_addr=0.
  task automatic do_reset;
    rst = 1'b1; hlt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step; step; step;
    rst = 1'b0;
    step; step;
  endtask

  task automatic test_reset;
    rst = 1'b1; hlt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step; step; step;
    total++; if (xreset !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL reset_xreset xreset=%b req=%b want 1/0", xreset, imem_req); end
    total++; if (insn !== NOP || insn_pc !== 32'h0 || imem_addr !== 32'h0) begin bad++; $display("FAIL reset_regs insn=%h pc=%h addr=%h want %h/0/0", insn, insn_pc, imem_addr, NOP); end
    total++; if (flush !== 1'b0 || misalign !== 1'b0) begin bad++; $display("FAIL reset_flags flush=%b mis=%b want 0/0", flush, misalign); end
    rst = 1'b0;
    step;
    total++; if (xreset !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL reset_stretch xreset=%b addr=%h want 1/0", xreset, imem_addr); end
    step;
    total++; if (xreset !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL reset_release xreset=%b req=%b addr=%h want 0/1/0", xreset, imem_req, imem_addr); end
    step;
    total++; if (imem_addr !== 32'h4 || insn !== NOP) begin bad++; $display("FAIL reset_first_fetch addr=%h insn=%h want 4/%h", imem_addr, insn, NOP); end
    for (int i = 0; i < 3; i++) begin
      step;
      total++;
      if (insn_pc !== 32'(4 * i) || insn !== mem_word(32'(4 * i)) || flush !== 1'b0) begin
        bad++; $display("FAIL reset_seq%0d insn_pc=%h insn=%h flush=%b want %h", i, insn_pc, insn, flush, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect;
    redirect = 1'b1; redirect_pc = 32'h100;
    step;
    redirect = 1'b0;
    total++; if (imem_addr !== 32'h100 || flush !== 1'b1 || misalign !== 1'b0) begin bad++; $display("FAIL redir_t1 addr=%h flush=%b mis=%b want 100/1/0", imem_addr, flush, misalign); end
    step;
    total++; if (flush !== 1'b1 || imem_addr !== 32'h104) begin bad++; $display("FAIL redir_t2 flush=%b addr=%h want 1/104", flush, imem_addr); end
    step;
    total++; if (flush !== 1'b0 || insn_pc !== 32'h100 || insn !== mem_word(32'h100)) begin bad++; $display("FAIL redir_t3 flush=%b insn_pc=%h insn=%h want 0/100", flush, insn_pc, insn); end
    step;
    total++; if (insn_pc !== 32'h104) begin bad++; $display("FAIL redir_t4 insn_pc=%h want 104", insn_pc); end
  endtask

  task automatic test_hold;
    logic [31:0] a0, i0, p0;
    a0 = imem_addr; i0 = insn; p0 = insn_pc;
    hlt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      total++;
      if (imem_addr !== a0 || insn !== i0 || insn_pc !== p0) begin
        bad++; $display("FAIL hold%0d addr=%h insn=%h pc=%h want %h/%h/%h", i, imem_addr, insn, insn_pc, a0, i0, p0);
      end
    end
    hlt = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step;
      total++;
      if (insn_pc !== p0 + 32'(4 * i) || insn !== mem_word(p0 + 32'(4 * i))) begin
        bad++; $display("FAIL hold_resume%0d insn_pc=%h insn=%h want %h", i, insn_pc, insn, p0 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_pending;
    logic [31:0] a0;
    a0 = imem_addr;
    hlt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step;
    redirect_pc = 32'h300;
    step;
    redirect = 1'b0;
    step;
    total++; if (imem_addr !== a0 || flush !== 1'b0) begin bad++; $display("FAIL pend_hold addr=%h flush=%b want %h/0", imem_addr, flush, a0); end
    hlt = 1'b0;
    step;
    total++; if (imem_addr !== 32'h300 || flush !== 1'b1) begin bad++; $display("FAIL pend_apply addr=%h flush=%b want 300/1", imem_addr, flush); end
    step;
    total++; if (imem_addr !== 32'h304 || flush !== 1'b1) begin bad++; $display("FAIL pend_flush2 addr=%h flush=%b want 304/1", imem_addr, flush); end
    step;
    total++; if (flush !== 1'b0 || insn_pc !== 32'h300 || insn_pc === 32'h200) begin bad++; $display("FAIL pend_target flush=%b insn_pc=%h want 0/300", flush, insn_pc); end
  endtask

  task automatic test_live_beats_pending;
    hlt = 1'b1; redirect = 1'b1; redirect_pc = 32'h800;
    step;
    hlt = 1'b0; redirect_pc = 32'h900;
    step;
    redirect = 1'b0;
    total++; if (imem_addr !== 32'h900) begin bad++; $display("FAIL live_wins addr=%h want 900", imem_addr); end
    step;
    total++; if (imem_addr !== 32'h904) begin bad++; $display("FAIL pend_cleared addr=%h want 904", imem_addr); end
    step;
  endtask

  task automatic test_misalign_wrap;
    redirect = 1'b1; redirect_pc = 32'h102;
    step;
    redirect = 1'b0;
    total++; if (imem_addr !== 32'h100 || misalign !== 1'b1) begin bad++; $display("FAIL misalign_apply addr=%h mis=%b want 100/1", imem_addr, misalign); end
    step;
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL misalign_pulse mis=%b want 0", misalign); end
    step;
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
    step;
    redirect = 1'b0;
    total++; if (imem_addr !== 32'hFFFFFFFC || misalign !== 1'b0) begin bad++; $display("FAIL wrap_target addr=%h mis=%b want fffffffc/0", imem_addr, misalign); end
    step;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero addr=%h want 0", imem_addr); end
    step;
    total++; if (insn_pc !== 32'hFFFFFFFC || insn !== mem_word(32'hFFFFFFFC) || flush !== 1'b0) begin bad++; $display("FAIL wrap_insn insn_pc=%h flush=%b want fffffffc/0", insn_pc, flush); end
    step;
    total++; if (insn_pc !== 32'h0) begin bad++; $display("FAIL wrap_insn_next insn_pc=%h want 0", insn_pc); end
  endtask

  task automatic test_redirect_in_flush;
    redirect = 1'b1; redirect_pc = 32'h400;
    step;
    redirect_pc = 32'h500;
    step;
    redirect = 1'b0;
    total++; if (imem_addr !== 32'h500 || flush !== 1'b1) begin bad++; $display("FAIL reflush_apply addr=%h flush=%b want 500/1", imem_addr, flush); end
    step;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL reflush_reload flush=%b want 1", flush); end
    step;
    total++; if (flush !== 1'b0 || insn_pc !== 32'h500) begin bad++; $display("FAIL reflush_done flush=%b insn_pc=%h want 0/500", flush, insn_pc); end
  endtask

  task automatic test_reset_mid_flush;
    redirect = 1'b1; redirect_pc = 32'h600;
    step;
    redirect = 1'b0; rst = 1'b1;
    step;
    total++; if (flush !== 1'b0 || imem_addr !== 32'h0 || xreset !== 1'b1 || insn !== NOP) begin bad++; $display("FAIL rst_flush flush=%b addr=%h xreset=%b insn=%h want 0/0/1/%h", flush, imem_addr, xreset, insn, NOP); end
    rst = 1'b0;
    step; step; step;
    total++; if (imem_addr !== 32'h4 || flush !== 1'b0) begin bad++; $display("FAIL rst_flush_recover addr=%h flush=%b want 4/0", imem_addr, flush); end
  endtask

  task automatic test_reset_mid_hold;
    hlt = 1'b1; redirect = 1'b1; redirect_pc = 32'h700;
    step;
    redirect = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0; hlt = 1'b0;
    step; step; step;
    total++; if (imem_addr !== 32'h4 || flush !== 1'b0) begin bad++; $display("FAIL rst_hold_pend addr=%h flush=%b want 4/0", imem_addr, flush); end
    step; step;
    total++; if (insn_pc !== 32'h4 || flush !== 1'b0) begin bad++; $display("FAIL rst_hold_seq insn_pc=%h flush=%b want 4/0", insn_pc, flush); end
  endtask

  initial begin
    rst = 1'b1; hlt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset;
    test_redirect;
    test_hold;
    test_pending;
    test_live_beats_pending;
    test_misalign_wrap;
    test_redirect_in_flush;
    test_reset_mid_flush;
    do_reset;
    step; step;
    test_reset_mid_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
